// File: rtl/sdram_req_sched_pkg.sv
// Shared types for the SDRAM request scheduler: command encodings, FSM states
// and the application-address to bank/row/column decode.
package sdram_sched_pkg;

    typedef enum logic [2:0] {
        CMD_NOP    = 3'd0,
        CMD_ACT    = 3'd1,
        CMD_PRE    = 3'd2,
        CMD_PREALL = 3'd3,
        CMD_RD     = 3'd4,
        CMD_WR     = 3'd5,
        CMD_REF    = 3'd6
    } cmd_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT_RP,
        ST_ACT,
        ST_WAIT_RCD,
        ST_RW,
        ST_PREALL,
        ST_WAIT_RPA,
        ST_REF
    } state_e;

    typedef struct packed {
        logic [1:0]  bank;
        logic [11:0] row;
        logic [11:0] col;
    } addr_dec_t;

    // Column width is 8..11 bits; bank sits directly above it, row above the bank.
    function automatic addr_dec_t addr_decode(input logic [31:0] addr, input logic [1:0] colbits);
        addr_dec_t   d;
        logic [31:0] col_mask;
        logic [31:0] upper;
        col_mask = (32'd1 << (32'd8 + 32'(colbits))) - 32'd1;
        upper    = addr >> (32'd8 + 32'(colbits));
        d.col    = 12'(addr & col_mask);
        d.bank   = upper[1:0];
        d.row    = upper[13:2];
        return d;
    endfunction

endpackage

// File: rtl/sdram_req_sched_if.sv
// Request and command handshake bundle between the application, the scheduler
// and the SDRAM command issue stage.
interface sdram_req_sched_if
    import sdram_sched_pkg::*;
#(
    parameter int APP_AW = 26
);
    logic              req_valid;
    logic              req_ready;
    logic [APP_AW-1:0] req_addr;
    logic              req_wr;
    logic              cmd_valid;
    logic              cmd_ready;
    cmd_e              cmd_type;
    logic [1:0]        cmd_bank;
    logic [11:0]       cmd_row;
    logic [11:0]       cmd_col;

    modport master (
        output req_valid, req_addr, req_wr, cmd_ready,
        input  req_ready, cmd_valid, cmd_type, cmd_bank, cmd_row, cmd_col
    );

    modport slave (
        input  req_valid, req_addr, req_wr, cmd_ready,
        output req_ready, cmd_valid, cmd_type, cmd_bank, cmd_row, cmd_col
    );
endinterface

// File: rtl/sdram_req_sched_bank_tracker.sv
// Open-row table for the four SDRAM banks: which banks are open and which row
// each open bank holds, with a combinational hit lookup.
module sdram_bank_tracker (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_en,
    input  logic [1:0]  set_bank,
    input  logic [11:0] set_row,
    input  logic        clr_en,
    input  logic [1:0]  clr_bank,
    input  logic        clr_all,
    input  logic [1:0]  look_bank,
    input  logic [11:0] look_row,
    output logic        look_open,
    output logic        look_hit,
    output logic [3:0]  bank_open,
    output logic        any_open
);
    logic [11:0] row_tbl [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_open <= '0;
        end else if (clr_all) begin
            bank_open <= '0;
        end else begin
            if (clr_en) bank_open[clr_bank] <= 1'b0;
            if (set_en) bank_open[set_bank] <= 1'b1;
        end
    end

    // Row entries are only meaningful while the matching open flag is set.
    always_ff @(posedge clk) begin
        if (set_en) row_tbl[set_bank] <= set_row;
    end

    assign look_open = bank_open[look_bank];
    assign look_hit  = look_open && (row_tbl[look_bank] == look_row);
    assign any_open  = |bank_open;

endmodule

// File: rtl/sdram_req_sched.sv
// Request scheduler: turns application reads/writes into the minimal
// PRE/ACT/RD/WR sequence, honouring tRP/tRCD/tWR, and services refresh.
module sdram_req_sched
    import sdram_sched_pkg::*;
#(
    parameter int APP_AW = 26,
    parameter int TRP    = 3,
    parameter int TRCD   = 3,
    parameter int TWR    = 2
) (
    input  logic                    sdram_clk,
    input  logic                    sdram_resetn,
    input  logic [1:0]              cfg_colbits,
    sdram_req_sched_if.slave        bus,
    input  logic                    ref_req,
    output logic                    ref_ack,
    output logic [3:0]              bank_open
);
    localparam int TMAX = (TRP > TRCD) ? TRP : TRCD;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int WW   = $clog2(TWR + 1);

    state_e      state;
    cmd_e        cmd_type;
    cmd_e        rw_cmd;
    logic        cmd_valid;
    logic [1:0]  cmd_bank;
    logic [11:0] cmd_row;
    logic [11:0] cmd_col;
    logic [TW-1:0] tmr;
    logic [WW-1:0] twr;
    logic [1:0]  cfg_q;
    logic [11:0] rq_row;
    logic [11:0] rq_col;
    logic        rq_wr;
    logic [APP_AW-1:0] addr;
    addr_dec_t   dec;
    logic        cfg_chg;
    logic        cmd_fire;
    logic        req_fire;
    logic        twr_ok;
    logic        look_open;
    logic        look_hit;
    logic        any_open;

    assign addr     = bus.req_addr;
    assign dec      = addr_decode(32'(addr), cfg_colbits);
    assign cfg_chg  = (state == ST_IDLE) && (cfg_colbits != cfg_q);
    assign bus.req_ready = sdram_resetn && (state == ST_IDLE) && !ref_req && !cfg_chg;
    assign req_fire = bus.req_valid && bus.req_ready;
    assign cmd_fire = cmd_valid && bus.cmd_ready;
    assign ref_ack  = (state == ST_REF) && cmd_fire;
    assign rw_cmd   = rq_wr ? CMD_WR : CMD_RD;
    // twr reaches zero on the next edge, so a precharge may be presented then.
    assign twr_ok   = (twr <= WW'(1));

    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_type  = cmd_type;
    assign bus.cmd_bank  = cmd_bank;
    assign bus.cmd_row   = cmd_row;
    assign bus.cmd_col   = cmd_col;

    sdram_bank_tracker u_tracker (
        .clk       (sdram_clk),
        .rst_n     (sdram_resetn),
        .set_en    ((state == ST_ACT) && cmd_fire),
        .set_bank  (cmd_bank),
        .set_row   (cmd_row),
        .clr_en    ((state == ST_PRE) && cmd_fire),
        .clr_bank  (cmd_bank),
        .clr_all   ((state == ST_PREALL) && cmd_fire),
        .look_bank (dec.bank),
        .look_row  (dec.row),
        .look_open (look_open),
        .look_hit  (look_hit),
        .bank_open (bank_open),
        .any_open  (any_open)
    );

    always_ff @(posedge sdram_clk) begin
        if (req_fire) begin
            rq_row <= dec.row;
            rq_col <= dec.col;
            rq_wr  <= bus.req_wr;
        end
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state     <= ST_IDLE;
            cmd_valid <= 1'b0;
            cmd_type  <= CMD_NOP;
            cmd_bank  <= '0;
            cmd_row   <= '0;
            cmd_col   <= '0;
            tmr       <= '0;
            twr       <= '0;
            cfg_q     <= '0;
        end else begin
            if (cmd_fire && cmd_type == CMD_WR) twr <= WW'(TWR - 1);
            else if (twr != '0)                 twr <= twr - WW'(1);

            case (state)
                ST_IDLE: begin
                    if (ref_req || cfg_chg) begin
                        if (any_open) begin
                            state     <= ST_PREALL;
                            cmd_type  <= CMD_PREALL;
                            cmd_bank  <= '0;
                            cmd_valid <= twr_ok;
                        end else begin
                            if (cfg_chg) cfg_q <= cfg_colbits;
                            if (ref_req) begin
                                state     <= ST_REF;
                                cmd_type  <= CMD_REF;
                                cmd_bank  <= '0;
                                cmd_valid <= 1'b1;
                            end
                        end
                    end else if (req_fire) begin
                        cmd_bank <= dec.bank;
                        if (look_hit) begin
                            state     <= ST_RW;
                            cmd_type  <= bus.req_wr ? CMD_WR : CMD_RD;
                            cmd_col   <= dec.col;
                            cmd_valid <= 1'b1;
                        end else if (look_open) begin
                            state     <= ST_PRE;
                            cmd_type  <= CMD_PRE;
                            cmd_valid <= twr_ok;
                        end else begin
                            state     <= ST_ACT;
                            cmd_type  <= CMD_ACT;
                            cmd_row   <= dec.row;
                            cmd_valid <= 1'b1;
                        end
                    end
                end
                ST_PRE: begin
                    if (cmd_fire) begin
                        if (TRP > 1) begin
                            state     <= ST_WAIT_RP;
                            tmr       <= TW'(TRP - 1);
                            cmd_valid <= 1'b0;
                            cmd_type  <= CMD_NOP;
                        end else begin
                            state    <= ST_ACT;
                            cmd_type <= CMD_ACT;
                            cmd_row  <= rq_row;
                        end
                    end else if (!cmd_valid) begin
                        cmd_valid <= twr_ok;
                    end
                end
                ST_WAIT_RP: begin
                    if (tmr <= TW'(1)) begin
                        state     <= ST_ACT;
                        cmd_type  <= CMD_ACT;
                        cmd_row   <= rq_row;
                        cmd_valid <= 1'b1;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                ST_ACT: begin
                    if (cmd_fire) begin
                        if (TRCD > 1) begin
                            state     <= ST_WAIT_RCD;
                            tmr       <= TW'(TRCD - 1);
                            cmd_valid <= 1'b0;
                            cmd_type  <= CMD_NOP;
                        end else begin
                            state    <= ST_RW;
                            cmd_type <= rw_cmd;
                            cmd_col  <= rq_col;
                        end
                    end
                end
                ST_WAIT_RCD: begin
                    if (tmr <= TW'(1)) begin
                        state     <= ST_RW;
                        cmd_type  <= rw_cmd;
                        cmd_col   <= rq_col;
                        cmd_valid <= 1'b1;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                ST_RW: begin
                    if (cmd_fire) begin
                        state     <= ST_IDLE;
                        cmd_valid <= 1'b0;
                        cmd_type  <= CMD_NOP;
                    end
                end
                ST_PREALL: begin
                    if (cmd_fire) begin
                        cfg_q <= cfg_colbits;
                        if (TRP > 1) begin
                            state     <= ST_WAIT_RPA;
                            tmr       <= TW'(TRP - 1);
                            cmd_valid <= 1'b0;
                            cmd_type  <= CMD_NOP;
                        end else if (ref_req) begin
                            state    <= ST_REF;
                            cmd_type <= CMD_REF;
                        end else begin
                            state     <= ST_IDLE;
                            cmd_valid <= 1'b0;
                            cmd_type  <= CMD_NOP;
                        end
                    end else if (!cmd_valid) begin
                        cmd_valid <= twr_ok;
                    end
                end
                ST_WAIT_RPA: begin
                    if (tmr <= TW'(1)) begin
                        if (ref_req) begin
                            state     <= ST_REF;
                            cmd_type  <= CMD_REF;
                            cmd_valid <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                ST_REF: begin
                    if (cmd_fire) begin
                        state     <= ST_IDLE;
                        cmd_valid <= 1'b0;
                        cmd_type  <= CMD_NOP;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_valid <= 1'b0;
                    cmd_type  <= CMD_NOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_req_sched.sv
// Bench for sdram_req_sched: directed requests, expected commands queued by the
// stimulus and popped by a monitor on every command handshake.
module tb_sdram_req_sched;
    import sdram_sched_pkg::*;

    localparam int TRP  = 3;
    localparam int TRCD = 3;
    localparam int TWR  = 2;

    typedef struct {
        cmd_e        t;
        logic [1:0]  b;
        logic [11:0] r;
        logic [11:0] c;
        int          gap;
        bit          from_acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] cfg = 2'd0;
    logic       ref_req = 1'b0;
    logic       ref_ack;
    logic [3:0] bank_open;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_fire = 0;
    int   last_acc = 0;
    int   ack_cnt = 0;
    int   ack0 = 0;
    exp_t q[$];
    exp_t mon_e;
    bit   mon_ok;
    int   mon_gap;
    bit   got;

    sdram_req_sched_if #(.APP_AW(26)) bus();

    sdram_req_sched #(.APP_AW(26), .TRP(TRP), .TRCD(TRCD), .TWR(TWR)) dut (
        .sdram_clk    (clk),
        .sdram_resetn (rstn),
        .cfg_colbits  (cfg),
        .bus          (bus),
        .ref_req      (ref_req),
        .ref_ack      (ref_ack),
        .bank_open    (bank_open)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void expect_cmd(cmd_e t, logic [1:0] b, logic [11:0] r, logic [11:0] c,
                                       int gap, bit from_acc);
        exp_t e;
        e.t = t; e.b = b; e.r = r; e.c = c; e.gap = gap; e.from_acc = from_acc;
        q.push_back(e);
    endfunction

    // Monitor: every command handshake is matched against the head of the queue.
    always @(negedge clk) begin
        if (ref_ack) ack_cnt++;
        if (rstn && bus.cmd_valid && bus.cmd_ready) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_cmd got type=%0d bank=%0d row=%0h col=%0h",
                         bus.cmd_type, bus.cmd_bank, bus.cmd_row, bus.cmd_col);
            end else begin
                mon_e  = q.pop_front();
                mon_ok = (bus.cmd_type == mon_e.t);
                if (mon_e.t inside {CMD_ACT, CMD_PRE, CMD_RD, CMD_WR}) mon_ok &= (bus.cmd_bank == mon_e.b);
                if (mon_e.t == CMD_ACT) mon_ok &= (bus.cmd_row == mon_e.r);
                if (mon_e.t inside {CMD_RD, CMD_WR}) mon_ok &= (bus.cmd_col == mon_e.c);
                total++;
                if (!mon_ok) begin
                    bad++;
                    $display("FAIL cmd got type=%0d bank=%0d row=%0h col=%0h want type=%0d bank=%0d row=%0h col=%0h",
                             bus.cmd_type, bus.cmd_bank, bus.cmd_row, bus.cmd_col,
                             mon_e.t, mon_e.b, mon_e.r, mon_e.c);
                end
                if (mon_e.gap >= 0) begin
                    mon_gap = mon_e.from_acc ? (cyc - last_acc) : (cyc - last_fire);
                    chk($sformatf("cmd_gap_type%0d", mon_e.t), mon_gap, mon_e.gap);
                end
                if (mon_e.t == CMD_REF) chk("ref_ack_on_ref", 32'(ref_ack), 32'd1);
            end
            last_fire = cyc;
        end
        if (bus.req_valid && bus.req_ready) last_acc = cyc;
    end

    task automatic wait_accept();
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ready) got = 1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL accept_timeout addr=%h", bus.req_addr);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic send(input logic [25:0] a, input logic w);
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_wr    = w;
        wait_accept();
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_wr    = 1'b0;
        bus.cmd_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        chk("rst_cmd_type", 32'(bus.cmd_type), 32'd0);
        chk("rst_cmd_fields", {6'd0, bus.cmd_bank, bus.cmd_row, bus.cmd_col}, 32'd0);
        chk("rst_ref_ack", 32'(ref_ack), 32'd0);
        chk("rst_bank_open", 32'(bank_open), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Closed bank: ACT b0 r6, then RD exactly TRCD after the ACT handshake.
        expect_cmd(CMD_ACT, 2'd0, 12'h006, 12'h000, 1, 1'b1);
        expect_cmd(CMD_RD,  2'd0, 12'h000, 12'h080, TRCD, 1'b0);
        send(26'h0001880, 1'b0);
        drain();
        chk("open_after_first", 32'(bank_open), 32'h1);

        // Row hit: WR one cycle after accept, no ACT/PRE.
        expect_cmd(CMD_WR, 2'd0, 12'h000, 12'h080, 1, 1'b1);
        send(26'h0001880, 1'b1);
        drain();

        // Row miss: PRE b0, ACT r8 after TRP, WR after TRCD.
        expect_cmd(CMD_PRE, 2'd0, 12'h000, 12'h000, -1, 1'b0);
        expect_cmd(CMD_ACT, 2'd0, 12'h008, 12'h000, TRP, 1'b0);
        expect_cmd(CMD_WR,  2'd0, 12'h000, 12'h080, TRCD, 1'b0);
        send(26'h0002080, 1'b1);
        drain();
        chk("open_after_miss", 32'(bank_open), 32'h1);

        // Open bank 2 as well, then refresh collides with a pending request.
        expect_cmd(CMD_ACT, 2'd2, 12'h000, 12'h000, 1, 1'b1);
        expect_cmd(CMD_RD,  2'd2, 12'h000, 12'h000, TRCD, 1'b0);
        send(26'h0000200, 1'b0);
        drain();
        chk("open_b0_b2", 32'(bank_open), 32'h5);

        ack0 = ack_cnt;
        expect_cmd(CMD_PREALL, 2'd0, 12'h000, 12'h000, -1, 1'b0);
        expect_cmd(CMD_REF,    2'd0, 12'h000, 12'h000, TRP, 1'b0);
        expect_cmd(CMD_ACT,    2'd0, 12'h006, 12'h000, 1, 1'b1);
        expect_cmd(CMD_RD,     2'd0, 12'h000, 12'h080, TRCD, 1'b0);
        @(posedge clk); #1;
        ref_req       = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 26'h0001880;
        bus.req_wr    = 1'b0;
        @(negedge clk);
        chk("ref_blocks_req", 32'(bus.req_ready), 32'd0);
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (ref_ack) got = 1;
        end
        chk("ref_ack_seen", 32'(got), 32'd1);
        chk("ref_banks_closed", 32'(bank_open), 32'd0);
        @(posedge clk); #1;
        ref_req = 1'b0;
        wait_accept();
        drain();
        chk("ref_ack_pulses", 32'(ack_cnt - ack0), 32'd1);

        // ACT held off by cmd_ready=0: fields must not move; TRCD counts from the handshake.
        expect_cmd(CMD_ACT, 2'd1, 12'h005, 12'h000, -1, 1'b0);
        expect_cmd(CMD_RD,  2'd1, 12'h000, 12'h000, TRCD, 1'b0);
        bus.cmd_ready = 1'b0;
        send(26'h0001500, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", {14'd0, bus.cmd_valid, 3'(bus.cmd_type), bus.cmd_bank, bus.cmd_row},
                {14'd0, 1'b1, 3'd1, 2'd1, 12'h005});
        end
        @(posedge clk); #1;
        bus.cmd_ready = 1'b1;
        drain();

        // Column width change closes all banks; new decode gives b3 r0 col 0x080.
        expect_cmd(CMD_PREALL, 2'd0, 12'h000, 12'h000, -1, 1'b0);
        @(posedge clk); #1;
        cfg = 2'd3;
        @(negedge clk);
        chk("cfgchg_blocks_req", 32'(bus.req_ready), 32'd0);
        drain();
        chk("cfgchg_banks_closed", 32'(bank_open), 32'd0);
        expect_cmd(CMD_ACT, 2'd3, 12'h000, 12'h000, 1, 1'b1);
        expect_cmd(CMD_RD,  2'd3, 12'h000, 12'h080, TRCD, 1'b0);
        send(26'h0001880, 1'b0);
        drain();
        chk("open_after_cfg", 32'(bank_open), 32'h8);

        // Reset while waiting tRCD: everything clears, next request re-activates.
        expect_cmd(CMD_ACT, 2'd2, 12'h000, 12'h000, 1, 1'b1);
        send(26'h0001000, 1'b0);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("midrst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        chk("midrst_bank_open", 32'(bank_open), 32'd0);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        expect_cmd(CMD_ACT, 2'd2, 12'h000, 12'h000, 1, 1'b1);
        expect_cmd(CMD_RD,  2'd2, 12'h000, 12'h000, TRCD, 1'b0);
        send(26'h0001000, 1'b0);
        drain();
        chk("open_after_rst", 32'(bank_open), 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
